// File: rtl/frame_pkg.sv
// Shared constants and the frame type handed from frame_loader to conv_layer.
package frame_pkg;
  localparam int IMG_SIZE = 5;
  localparam int IMG_CH   = 1;
  localparam int PX_W     = 8;
  localparam int FRAME_PX = IMG_SIZE * IMG_SIZE * IMG_CH;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int ROW_W = cnt_w(IMG_SIZE);
  localparam int COL_W = cnt_w(IMG_SIZE);
  localparam int CH_W  = cnt_w(IMG_CH);

  // Indexed [row][col][ch], identical in layout to conv_layer img_in.
  typedef logic [IMG_SIZE-1:0][IMG_SIZE-1:0][IMG_CH-1:0][PX_W-1:0] frame_t;
endpackage

// File: rtl/frame_raster_counter.sv
// Nested ch -> col -> row raster position counter; clear wins over advance.
module raster_counter
  import frame_pkg::*;
#(
  parameter int SIZE     = IMG_SIZE,
  parameter int CHANNELS = IMG_CH,
  parameter int RW       = cnt_w(SIZE),
  parameter int CW       = cnt_w(SIZE),
  parameter int HW       = cnt_w(CHANNELS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  input  logic          clear,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [HW-1:0] ch,
  output logic          last
);
  localparam logic [RW-1:0] ROW_MAX = RW'(SIZE - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(SIZE - 1);
  localparam logic [HW-1:0] CH_MAX  = HW'(CHANNELS - 1);

  assign last = (row == ROW_MAX) && (col == COL_MAX) && (ch == CH_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      row <= '0;
      col <= '0;
      ch  <= '0;
    end else if (advance) begin
      if (ch == CH_MAX) begin
        ch <= '0;
        if (col == COL_MAX) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        ch <= ch + 1'b1;
      end
    end
  end
endmodule

// File: rtl/frame_loader.sv
// Ping-pong frame assembler: fills one bank from a raster stream while the
// other is presented to conv_layer until acknowledged.
module frame_loader
  import frame_pkg::*;
#(
  parameter int INPUT_SIZE     = IMG_SIZE,
  parameter int INPUT_CHANNELS = IMG_CH,
  parameter int PX_SIZE        = PX_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [PX_SIZE-1:0] px_in,
  input  logic px_valid,
  input  logic px_last,
  output logic px_ready,
  output logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] frame_out,
  output logic frame_valid,
  input  logic frame_ack,
  output logic frame_err
);
  localparam int RW = cnt_w(INPUT_SIZE);
  localparam int CW = cnt_w(INPUT_SIZE);
  localparam int HW = cnt_w(INPUT_CHANNELS);

  typedef logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] bank_t;

  bank_t          bank [2];
  logic [1:0]     bank_full;
  logic           wr_bank, rd_bank;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [HW-1:0]  ch;
  logic           at_last, xfer, complete, early, ack;

  assign px_ready    = !bank_full[wr_bank];
  assign frame_valid = bank_full[rd_bank];
  assign frame_out   = bank[rd_bank];

  assign xfer     = px_valid && px_ready;
  assign complete = xfer && at_last;
  assign early    = xfer && px_last && !at_last;
  assign ack      = frame_ack && frame_valid;

  raster_counter #(
    .SIZE(INPUT_SIZE), .CHANNELS(INPUT_CHANNELS), .RW(RW), .CW(CW), .HW(HW)
  ) u_cnt (
    .clk(clk), .rst_n(rst_n), .advance(xfer), .clear(early),
    .row(row), .col(col), .ch(ch), .last(at_last)
  );

  // Completion only targets an empty wr_bank, so it can never collide with
  // an ack on the full rd_bank; both updates land in the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank[0]   <= '0;
      bank[1]   <= '0;
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (xfer)
        bank[wr_bank][row][col][ch] <= px_in;
      if (ack) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= !rd_bank;
      end
      if (complete) begin
        bank_full[wr_bank] <= 1'b1;
        wr_bank            <= !wr_bank;
      end
      if (early || (complete && !px_last))
        frame_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_frame_loader.sv
// Scenario bench for frame_loader against a queue-based model of presented frames.
module tb_frame_loader;
  import frame_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PX_W-1:0] px_in = '0;
  logic          px_valid = 1'b0, px_last = 1'b0, frame_ack = 1'b0;
  logic          px_ready, frame_valid, frame_err;
  frame_t        frame_out;

  int n_tests = 0, n_fail = 0;

  typedef int img_t [FRAME_PX];
  img_t fq[$];
  int   part[$];
  bit   m_err;
  int   n_xfer;

  frame_loader dut (
    .clk(clk), .rst_n(rst_n), .px_in(px_in), .px_valid(px_valid), .px_last(px_last),
    .px_ready(px_ready), .frame_out(frame_out), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the model advances on the same rules the consumer sees.
  task automatic step(input bit v, input int d, input bit l, input bit a);
    bit xfer, ackd;
    img_t f;
    px_valid = v; px_in = PX_W'(d); px_last = l; frame_ack = a;
    xfer = v && (fq.size() < 2);
    ackd = a && (fq.size() > 0);
    if (ackd) fq.delete(0);
    if (xfer) begin
      n_xfer++;
      part.push_back(d);
      if (part.size() == FRAME_PX) begin
        foreach (f[i]) f[i] = part[i];
        fq.push_back(f);
        if (!l) m_err = 1'b1;
        part.delete();
      end else if (l) begin
        m_err = 1'b1;
        part.delete();
      end
    end
    @(posedge clk); #1;
    px_valid = 1'b0; px_last = 1'b0; frame_ack = 1'b0;
  endtask

  task automatic stream(input int base, input int n, input bit last_on_final);
    for (int i = 0; i < n; i++) step(1'b1, base + i, last_on_final && (i == n - 1), 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; px_valid = 1'b0; px_last = 1'b0; frame_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fq.delete(); part.delete(); m_err = 1'b0;
  endtask

  function automatic frame_t exp_frame();
    frame_t e = '0;
    if (fq.size() > 0)
      for (int r = 0; r < IMG_SIZE; r++)
        for (int c = 0; c < IMG_SIZE; c++)
          for (int h = 0; h < IMG_CH; h++)
            e[r][c][h] = PX_W'(fq[0][(r * IMG_SIZE + c) * IMG_CH + h]);
    return e;
  endfunction

  task automatic test_reset();
    do_reset();
    n_tests++; if (px_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", px_ready); end
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_err); end
    n_tests++; if (frame_out !== '0) begin n_fail++; $display("FAIL reset_frame: got %h want 0", frame_out); end
  endtask

  task automatic test_single_frame();
    stream(1, 24, 1'b0);
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", frame_valid); end
    step(1'b1, 25, 1'b1, 1'b0);
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", frame_valid); end
    n_tests++; if (frame_out[0][0][0] !== 8'd1) begin n_fail++; $display("FAIL single_px00: got %0d want 1", frame_out[0][0][0]); end
    n_tests++; if (frame_out[0][4][0] !== 8'd5) begin n_fail++; $display("FAIL single_px04: got %0d want 5", frame_out[0][4][0]); end
    n_tests++; if (frame_out[4][4][0] !== 8'd25) begin n_fail++; $display("FAIL single_px44: got %0d want 25", frame_out[4][4][0]); end
    n_tests++; if (frame_out !== exp_frame()) begin n_fail++; $display("FAIL single_frame: got %h want %h", frame_out, exp_frame()); end
    n_tests++; if (px_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", px_ready); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", frame_err); end
    step(1'b0, 0, 1'b0, 1'b1);
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack: got %b want 0", frame_valid); end
  endtask

  task automatic test_two_frames();
    stream(1, 25, 1'b1);
    stream(101, 25, 1'b1);
    n_tests++; if (px_ready !== 1'b0) begin n_fail++; $display("FAIL two_ready_full: got %b want 0", px_ready); end
    n_tests++; if (frame_out[0][0][0] !== 8'd1) begin n_fail++; $display("FAIL two_first: got %0d want 1", frame_out[0][0][0]); end
    step(1'b0, 0, 1'b0, 1'b1);
    n_tests++; if (frame_out[0][0][0] !== 8'd101) begin n_fail++; $display("FAIL two_second: got %0d want 101", frame_out[0][0][0]); end
    n_tests++; if (px_ready !== 1'b1) begin n_fail++; $display("FAIL two_ready_after_ack: got %b want 1", px_ready); end
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL two_no_gap: got %b want 1", frame_valid); end
    n_tests++; if (frame_out !== exp_frame()) begin n_fail++; $display("FAIL two_frame: got %h want %h", frame_out, exp_frame()); end
    step(1'b0, 0, 1'b0, 1'b1);
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL two_drained: got %b want 0", frame_valid); end
  endtask

  task automatic test_backpressure();
    int start = n_xfer;
    for (int k = 0; k < 60; k++) begin
      n_tests++;
      if (px_ready !== (k < 50)) begin n_fail++; $display("FAIL bp_ready_c%0d: got %b want %b", k, px_ready, k < 50); end
      step(1'b1, 30 + k, part.size() == FRAME_PX - 1, 1'b0);
    end
    n_tests++; if (n_xfer - start != 50) begin n_fail++; $display("FAIL bp_count: got %0d want 50", n_xfer - start); end
    n_tests++; if (frame_out[0][0][0] !== 8'd30) begin n_fail++; $display("FAIL bp_first: got %0d want 30", frame_out[0][0][0]); end
    n_tests++; if (frame_out !== exp_frame()) begin n_fail++; $display("FAIL bp_frame0: got %h want %h", frame_out, exp_frame()); end
    step(1'b0, 0, 1'b0, 1'b1);
    n_tests++; if (frame_out[4][4][0] !== 8'd79) begin n_fail++; $display("FAIL bp_last: got %0d want 79", frame_out[4][4][0]); end
    n_tests++; if (frame_out !== exp_frame()) begin n_fail++; $display("FAIL bp_frame1: got %h want %h", frame_out, exp_frame()); end
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_early_last();
    do_reset();
    stream(1, 9, 1'b0);
    step(1'b1, 10, 1'b1, 1'b0);
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL early_err: got %b want 1", frame_err); end
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid: got %b want 0", frame_valid); end
    stream(200, 25, 1'b1);
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL early_next_valid: got %b want 1", frame_valid); end
    n_tests++; if (frame_out[0][0][0] !== 8'd200) begin n_fail++; $display("FAIL early_px00: got %0d want 200", frame_out[0][0][0]); end
    n_tests++; if (frame_out[4][4][0] !== 8'd224) begin n_fail++; $display("FAIL early_px44: got %0d want 224", frame_out[4][4][0]); end
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL early_sticky: got %b want 1", frame_err); end
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_missing_last();
    do_reset();
    stream(50, 25, 1'b0);
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL nolast_valid: got %b want 1", frame_valid); end
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL nolast_err: got %b want 1", frame_err); end
    n_tests++; if (frame_out !== exp_frame()) begin n_fail++; $display("FAIL nolast_frame: got %h want %h", frame_out, exp_frame()); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    stream(1, 12, 1'b0);
    do_reset();
    n_tests++; if (px_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", px_ready); end
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", frame_valid); end
    n_tests++; if (frame_out !== '0) begin n_fail++; $display("FAIL midrst_frame: got %h want 0", frame_out); end
    stream(60, 25, 1'b1);
    n_tests++; if (frame_out[0][0][0] !== 8'd60) begin n_fail++; $display("FAIL midrst_px00: got %0d want 60", frame_out[0][0][0]); end
    n_tests++; if (frame_out !== exp_frame()) begin n_fail++; $display("FAIL midrst_fresh: got %h want %h", frame_out, exp_frame()); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b want 0", frame_err); end
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_stray_ack();
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL stray_valid: got %b want 0", frame_valid); end
    n_tests++; if (px_ready !== 1'b1) begin n_fail++; $display("FAIL stray_ready: got %b want 1", px_ready); end
    stream(7, 25, 1'b1);
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL stray_then_valid: got %b want 1", frame_valid); end
    n_tests++; if (frame_out !== exp_frame()) begin n_fail++; $display("FAIL stray_frame: got %h want %h", frame_out, exp_frame()); end
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    bit v, a, l;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      v = $urandom_range(0, 3) != 0;
      a = $urandom_range(0, 3) == 0;
      l = (part.size() == FRAME_PX - 1) ^ ($urandom_range(0, 59) == 0);
      step(v, int'($urandom_range(0, 255)), l, a);
      n_tests++; if (px_ready !== (fq.size() < 2)) begin n_fail++; $display("FAIL rnd_ready_c%0d: got %b want %b", k, px_ready, fq.size() < 2); end
      n_tests++; if (frame_valid !== (fq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid_c%0d: got %b want %b", k, frame_valid, fq.size() > 0); end
      n_tests++; if (frame_err !== m_err) begin n_fail++; $display("FAIL rnd_err_c%0d: got %b want %b", k, frame_err, m_err); end
      if (fq.size() > 0) begin
        n_tests++; if (frame_out !== exp_frame()) begin n_fail++; $display("FAIL rnd_frame_c%0d: got %h want %h", k, frame_out, exp_frame()); end
      end
    end
  endtask

  initial begin
    m_err = 1'b0; n_xfer = 0;
    test_reset();
    test_single_frame();
    test_two_frames();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_mid_reset();
    test_stray_ack();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
